// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store request at a time, waits a
// fixed latency, then presents a registered response until it is taken.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,  // 32-bit storage words (>= 2)
  parameter int LATENCY     = 2     // wait cycles, 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic        first_q;   // first WAIT cycle: decode request, load counter
  logic        err_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  func3_q;
  logic        fault;
  logic        commit;
  logic [AW-1:0] idx;
  logic [1:0]  lane;
  logic [31:0] rd_word, rd_shift, load_val, st_mask, st_data, merged;

  logic [31:0] mem [DEPTH_WORDS];

  assign idx  = addr_q[AW+1:2];
  assign lane = addr_q[1:0];

  // Classify the captured request: illegal funct3, misalignment, out of range.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    fault = 1'b0;
    if (we_q) fault = !(func3_q inside {3'b000, 3'b001, 3'b010});
    else      fault = !(func3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    case (func3_q[1:0])
      2'b01:   if (addr_q[0])          fault = 1'b1;
      2'b10:   if (addr_q[1:0] != 2'b00) fault = 1'b1;
      default: ;
    endcase
    if ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS)) fault = 1'b1;
  end

  // Load extraction and store byte-lane merge against the addressed word.
  always_comb begin
    rd_word  = mem[idx];
    rd_shift = rd_word >> {lane, 3'b000};
    load_val = 32'h0;
    case (func3_q)
      3'b000:  load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {24'h0, rd_shift[7:0]};
      3'b101:  load_val = {16'h0, rd_shift[15:0]};
      default: load_val = 32'h0;
    endcase
    case (func3_q[1:0])
      2'b00: begin
        st_mask = 32'h0000_00FF << {lane, 3'b000};
        st_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        st_mask = 32'h0000_FFFF << {lane, 3'b000};
        st_data = {2{wdata_q[15:0]}};
      end
      default: begin
        st_mask = 32'hFFFF_FFFF;
        st_data = wdata_q;
      end
    endcase
    merged = (rd_word & ~st_mask) | (st_data & st_mask);
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (req_valid) next_state = S_WAIT;
      S_WAIT:  if (!first_q && cnt == 4'd0) next_state = S_RESP;
      S_RESP:  if (rsp_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  assign commit = (state == S_WAIT) && (next_state == S_RESP);

  // State, request capture, latency counter and registered response outputs.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      first_q   <= 1'b0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      func3_q   <= 3'b000;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= next_state;
      req_ready <= (next_state == S_IDLE);
      rsp_valid <= (next_state == S_RESP);
      if (state == S_IDLE && req_valid) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        func3_q <= req_func3;
        first_q <= 1'b1;
      end
      if (state == S_WAIT) begin
        if (first_q) begin
          cnt     <= 4'(LATENCY - 1);
          first_q <= 1'b0;
          err_q   <= fault;
        end else if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end
      end
      if (commit) begin
        rsp_err   <= err_q;
        rsp_rdata <= (err_q || we_q) ? 32'h0 : load_val;
      end else if (state == S_RESP && rsp_ready) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= 32'h0;
      end
    end
  end

  // Storage: cleared by reset, written only by a fault-free store at commit.
  always_ff @(posedge clk) begin
    // NOTE: memories are normally left unreset; this array must read zero after reset, so it is cleared.
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'h0;
    end else if (commit && we_q && !err_q) begin
      mem[idx] <= merged;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder (default parameters).
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [2:0]  req_func3 = 3'b000;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_vec = 0;
  int n_err = 0;

  data_mem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_func3 (req_func3),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one request, wait (bounded) for the response, then take it.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] f3, output logic [31:0] rdata, output logic err,
                      output int lat);
    @(negedge clk);
    check("req_ready_idle", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_func3 = f3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1;
    rdata = 32'hx;
    err = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(posedge clk);
      else if (1) begin end
      if (k == 1) @(posedge clk);
      #1;
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    if (lat >= 0) begin
      rdata = rsp_rdata;
      err   = rsp_err;
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
    end
  endtask

  task automatic run(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [2:0] f3,
                     input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] d;
    logic        e;
    int          lat;
    xact(we, addr, wdata, f3, d, e, lat);
    check({tag, "_lat"}, lat, 32'd3);
    check({tag, "_err"}, {31'h0, e}, {31'h0, exp_err});
    check({tag, "_data"}, d, exp_data);
  endtask

  initial begin
    int seen;
    // Reset: outputs idle, storage cleared.
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", {31'h0, rsp_err}, 32'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    check("rst_ready", {31'h0, req_ready}, 32'h1);

    // Basic word store/load.
    run("sw_10",  1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0,        1'b0);
    run("lw_10",  1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0);
    // Byte store and sub-word loads.
    run("sb_11",  1'b1, 32'h11, 32'h0000007F, 3'b000, 32'h0,        1'b0);
    run("lb_13",  1'b0, 32'h13, 32'h0,        3'b000, 32'hFFFFFFDE, 1'b0);
    run("lbu_13", 1'b0, 32'h13, 32'h0,        3'b100, 32'h000000DE, 1'b0);
    run("lw_10b", 1'b0, 32'h10, 32'h0,        3'b010, 32'hDEAD7FEF, 1'b0);
    run("lh_12",  1'b0, 32'h12, 32'h0,        3'b001, 32'hFFFFDEAD, 1'b0);
    run("lhu_12", 1'b0, 32'h12, 32'h0,        3'b101, 32'h0000DEAD, 1'b0);
    run("lb_11",  1'b0, 32'h11, 32'h0,        3'b000, 32'h0000007F, 1'b0);
    // Faults: misaligned and out of range.
    run("lh_11",  1'b0, 32'h11, 32'h0,        3'b001, 32'h0,        1'b1);
    run("sw_402", 1'b1, 32'h402, 32'h11111111, 3'b010, 32'h0,       1'b1);
    run("lw_400", 1'b0, 32'h400, 32'h0,       3'b010, 32'h0,        1'b1);
    run("sw_12",  1'b1, 32'h12, 32'h55555555, 3'b010, 32'h0,        1'b1);
    run("lw_10c", 1'b0, 32'h10, 32'h0,        3'b010, 32'hDEAD7FEF, 1'b0);
    // Halfword store into the upper lanes.
    run("sh_12",  1'b1, 32'h12, 32'hFFFF1234, 3'b001, 32'h0,        1'b0);
    run("lw_10d", 1'b0, 32'h10, 32'h0,        3'b010, 32'h12347FEF, 1'b0);
    // Last word in range.
    run("sw_3fc", 1'b1, 32'h3FC, 32'hCAFEF00D, 3'b010, 32'h0,       1'b0);
    run("lw_3fc", 1'b0, 32'h3FC, 32'h0,       3'b010, 32'hCAFEF00D, 1'b0);
    // Illegal funct3 for the direction: no storage change.
    run("ld_f011", 1'b0, 32'h10, 32'h0,       3'b011, 32'h0,        1'b1);
    run("ld_f110", 1'b0, 32'h10, 32'h0,       3'b110, 32'h0,        1'b1);
    run("st_f100", 1'b1, 32'h10, 32'h0,       3'b100, 32'h0,        1'b1);
    run("lw_10e", 1'b0, 32'h10, 32'h0,        3'b010, 32'h12347FEF, 1'b0);

    // Response stall: outputs hold, requests ignored while not ready.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_func3 = 3'b010;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      @(posedge clk) #1;
      if (rsp_valid) seen = 1;
    end
    check("stall_arrive", seen, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = (i == 2); req_we = 1'b1; req_addr = 32'h10;
      req_wdata = 32'h0; req_func3 = 3'b010;
      @(posedge clk) #1;
      check("stall_valid", {31'h0, rsp_valid}, 32'h1);
      check("stall_rdata", rsp_rdata, 32'h12347FEF);
      check("stall_ready", {31'h0, req_ready}, 32'h0);
    end
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk) #1 rsp_ready = 1'b0;
    check("hs_valid", {31'h0, rsp_valid}, 32'h0);
    check("hs_rdata", rsp_rdata, 32'h0);
    check("hs_ready", {31'h0, req_ready}, 32'h1);
    run("lw_10f", 1'b0, 32'h10, 32'h0, 3'b010, 32'h12347FEF, 1'b0);

    // Reset during WAIT abandons the store and clears storage.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234; req_func3 = 3'b010;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    check("rstw_valid", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk) #1;
      if (rsp_valid) seen++;
    end
    check("rstw_norsp", seen, 32'd0);
    run("lw_20", 1'b0, 32'h20, 32'h0, 3'b010, 32'h0, 1'b0);
    run("lw_10g", 1'b0, 32'h10, 32'h0, 3'b010, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
